fifo_mon: RTL and testbench

Parametrised synchronous FIFO with first-word-fall-through read. It is the next generation of the basic FIFO used between UART/SPI front-ends and the core. It adds an asynchronous reset, a synchronous flush, programmable almost-full and almost-empty flags, an occupancy count output, a high-water mark, and sticky overflow/underflow error flags for debug.

---
 rtl/fifo_mon_if.sv | 41 ++++
 rtl/fifo_mon.sv | 97 +++++++++
 tb/tb_fifo_mon.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_mon_if.sv
// fifo_mon_if: bundle of the FIFO request/status signals.
//
// Handshake: there is no ready signal.
//   - A write is taken on a rising edge when i_wr=1 and o_full=0.
//   - A read is taken on a rising edge when i_rd=1 and o_empty=0.
//   - o_data always shows the head word; asserting i_rd acknowledges it.
//   - i_clr flushes the FIFO and overrides any request in the same cycle.
//   - Requests made against a full or empty FIFO are dropped and raise the
//     sticky o_ovf / o_unf flags.
//
// Modports:
//   master - producer/consumer side; drives the i_* signals.
//   slave  - FIFO side; drives the o_* signals.
interface fifo_mon_if #(
    parameter int DATA_SZ = 8,
    parameter int ADDR_SZ = 4
);
    logic               i_clr;
    logic               i_wr;
    logic [DATA_SZ-1:0] i_data;
    logic               i_rd;
    logic [DATA_SZ-1:0] o_data;
    logic               o_full;
    logic               o_afull;
    logic               o_empty;
    logic               o_aempty;
    logic [ADDR_SZ:0]   o_len;
    logic [ADDR_SZ:0]   o_hwm;
    logic               o_ovf;
    logic               o_unf;

    modport master (
        output i_clr, i_wr, i_data, i_rd,
        input  o_data, o_full, o_afull, o_empty, o_aempty, o_len, o_hwm, o_ovf, o_unf
    );

    modport slave (
        input  i_clr, i_wr, i_data, i_rd,
        output o_data, o_full, o_afull, o_empty, o_aempty, o_len, o_hwm, o_ovf, o_unf
    );
endinterface

// File: rtl/fifo_mon.sv
// fifo_mon: synchronous first-word-fall-through FIFO with monitoring.
// It provides the occupancy level, a high-water mark, programmable
// almost-full and almost-empty flags, and sticky overflow/underflow flags.
//
// Ports:
//   i_clk - clock; all state changes on the rising edge
//   i_rst - asynchronous, active-high reset
//   bus   - fifo_mon_if.slave: flush, write/read requests, data, status
module fifo_mon #(
    parameter int DATA_SZ    = 8,
    parameter int ADDR_SZ    = 4,
    parameter int AFULL_LVL  = (1 << ADDR_SZ) - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    fifo_mon_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_SZ;
    localparam logic [ADDR_SZ:0] AFULL_L  = (ADDR_SZ+1)'(AFULL_LVL);
    localparam logic [ADDR_SZ:0] AEMPTY_L = (ADDR_SZ+1)'(AEMPTY_LVL);

    // The pointers carry one extra bit, so a full FIFO and an empty FIFO
    // have different pointer values. The RAM is indexed by the low bits.
    logic [ADDR_SZ:0]   wr_ptr;
    logic [ADDR_SZ:0]   rd_ptr;
    logic [ADDR_SZ:0]   len;
    logic [ADDR_SZ:0]   len_nxt;
    logic [ADDR_SZ:0]   hwm;
    logic               ovf;
    logic               unf;
    logic               full;
    logic               empty;
    logic               wr_ok;
    logic               rd_ok;
    logic [DATA_SZ-1:0] mem [DEPTH];

    // Status comes straight from the registered level, with no added latency.
    assign full  = len[ADDR_SZ];
    assign empty = (len == '0);

    // Requests are accepted against the flags as they stand before the edge.
    assign wr_ok = bus.i_wr & ~full;
    assign rd_ok = bus.i_rd & ~empty;

    always_comb begin
        len_nxt = len;
        if (wr_ok && !rd_ok) begin
            len_nxt = len + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            len_nxt = len - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            hwm    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (bus.i_clr) begin
            // A flush overrides any request presented in the same cycle.
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            hwm    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            len <= len_nxt;
            if (len_nxt > hwm) hwm <= len_nxt;
            if (bus.i_wr && full)  ovf <= 1'b1;
            if (bus.i_rd && empty) unf <= 1'b1;
        end
    end

    // The RAM has no reset, so synthesis can map it to block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !bus.i_clr) begin
            mem[wr_ptr[ADDR_SZ-1:0]] <= bus.i_data;
        end
    end

    assign bus.o_data   = mem[rd_ptr[ADDR_SZ-1:0]];
    assign bus.o_full   = full;
    assign bus.o_empty  = empty;
    assign bus.o_afull  = (len >= AFULL_L);
    assign bus.o_aempty = (len <= AEMPTY_L);
    assign bus.o_len    = len;
    assign bus.o_hwm    = hwm;
    assign bus.o_ovf    = ovf;
    assign bus.o_unf    = unf;
endmodule

// File: tb/tb_fifo_mon.sv
module tb_fifo_mon;
    localparam int DATA_SZ = 8;
    localparam int ADDR_SZ = 4;
    localparam int DEPTH   = 16;

    logic clk;
    logic rst;

    fifo_mon_if #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ)) bus ();

    fifo_mon #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [DATA_SZ-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle with the given requests. If a read is expected to be
    // taken, the head word is checked before the edge. Outputs are sampled
    // 1 time unit after the edge.
    task automatic do_cycle(input logic wr, input logic rd, input logic [DATA_SZ-1:0] d);
        int pre;
        pre = exp_q.size();
        bus.i_wr   = wr;
        bus.i_rd   = rd;
        bus.i_data = d;
        if (rd && pre != 0) check("rd_data", bus.o_data, exp_q[0]);
        @(posedge clk);
        #1;
        if (rd && pre != 0) void'(exp_q.pop_front());
        if (wr && pre < DEPTH) exp_q.push_back(d);
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
    endtask

    task automatic do_clear(input logic wr, input logic [DATA_SZ-1:0] d);
        bus.i_clr  = 1'b1;
        bus.i_wr   = wr;
        bus.i_data = d;
        @(posedge clk);
        #1;
        bus.i_clr = 1'b0;
        bus.i_wr  = 1'b0;
        exp_q.delete();
    endtask

    task automatic fill(input int n, input logic [DATA_SZ-1:0] base);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, base + DATA_SZ'(i));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        bus.i_clr  = 1'b0;
        bus.i_wr   = 1'b0;
        bus.i_rd   = 1'b0;
        bus.i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. Reset/idle. Build up some state (unf=1, len=3, hwm=3), then
        //    assert reset asynchronously in the middle of a cycle.
        do_cycle(1'b0, 1'b1, '0);
        check("pre_rst_unf", bus.o_unf, 1);
        fill(3, 8'h70);
        check("pre_rst_len", bus.o_len, 3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_empty",  bus.o_empty, 1);
        check("rst_aempty", bus.o_aempty, 1);
        check("rst_full",   bus.o_full, 0);
        check("rst_afull",  bus.o_afull, 0);
        check("rst_len",    bus.o_len, 0);
        check("rst_hwm",    bus.o_hwm, 0);
        check("rst_ovf",    bus.o_ovf, 0);
        check("rst_unf",    bus.o_unf, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2. Fill 0x00..0x0F, then drain and check the order.
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 1'b0, DATA_SZ'(i));
            check("fill_len",    bus.o_len, i + 1);
            check("fill_afull",  bus.o_afull, (i + 1) >= 14);
            check("fill_full",   bus.o_full, (i + 1) == 16);
            check("fill_aempty", bus.o_aempty, (i + 1) <= 1);
        end
        check("fill_hwm", bus.o_hwm, 16);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_head", bus.o_data, i);
            do_cycle(1'b0, 1'b1, '0);
            check("drain_len",    bus.o_len, 15 - i);
            check("drain_aempty", bus.o_aempty, (15 - i) <= 1);
            check("drain_empty",  bus.o_empty, i == 15);
        end
        check("drain_hwm", bus.o_hwm, 16);

        // 3. Overflow/underflow flags.
        fill(DEPTH, 8'h20);
        do_cycle(1'b1, 1'b0, 8'hAA);
        check("ovf_len",  bus.o_len, 16);
        check("ovf_flag", bus.o_ovf, 1);
        check("ovf_head", bus.o_data, 8'h20);
        drain(DEPTH);
        do_cycle(1'b0, 1'b1, '0);
        check("unf_flag",   bus.o_unf, 1);
        check("unf_len",    bus.o_len, 0);
        check("ovf_sticky", bus.o_ovf, 1);
        do_cycle(1'b0, 1'b0, '0);
        check("unf_sticky", bus.o_unf, 1);
        do_clear(1'b0, '0);
        check("clr_ovf", bus.o_ovf, 0);
        check("clr_unf", bus.o_unf, 0);

        // 4. Simultaneous read and write. The pointers wrap past 15 while the
        //    level stays at 5.
        fill(5, 8'h40);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 1'b1, 8'h80 + DATA_SZ'(i));
            check("rw_len", bus.o_len, 5);
        end
        check("rw_hwm", bus.o_hwm, 5);
        drain(5);
        check("rw_drained", bus.o_empty, 1);
        do_cycle(1'b1, 1'b1, 8'hE1);
        check("rw_empty_len", bus.o_len, 1);
        check("rw_empty_unf", bus.o_unf, 1);
        check("rw_empty_dat", bus.o_data, 8'hE1);
        do_clear(1'b0, '0);
        fill(DEPTH, 8'hC0);
        do_cycle(1'b1, 1'b1, 8'hEE);
        check("rw_full_len", bus.o_len, 15);
        check("rw_full_ovf", bus.o_ovf, 1);
        check("rw_full_hd",  bus.o_data, 8'hC1);
        do_clear(1'b0, '0);

        // 5. Fall-through latency.
        do_cycle(1'b1, 1'b0, 8'h5C);
        check("ft_empty", bus.o_empty, 0);
        check("ft_data",  bus.o_data, 8'h5C);
        do_cycle(1'b0, 1'b1, '0);
        check("ft_empty2", bus.o_empty, 1);

        // 6. A flush takes priority over a write in the same cycle.
        fill(DEPTH, 8'h00);
        do_cycle(1'b1, 1'b0, 8'hAB);
        drain(7);
        check("pre_clr_len", bus.o_len, 9);
        check("pre_clr_ovf", bus.o_ovf, 1);
        do_clear(1'b1, 8'h33);
        check("clr_len",   bus.o_len, 0);
        check("clr_hwm",   bus.o_hwm, 0);
        check("clr_ovf2",  bus.o_ovf, 0);
        check("clr_empty", bus.o_empty, 1);
        do_cycle(1'b1, 1'b0, 8'h44);
        check("post_clr_data", bus.o_data, 8'h44);
        check("post_clr_len",  bus.o_len, 1);
        drain(1);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
